bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Iterative, clocked binary-to-BCD converter for the display path.
- Successor to the combinational double-dabble converter, with parametrised width and digit count.
- Processes one input bit per clock. Uses a start/busy/done handshake and registered outputs.
- Adds optional signed/absolute mode, overflow detection and a leading-zero blank mask for the 7-seg driver.

Parameters:
- WIDTH, 16, binary input width (>= 2).
- DIGITS, 5, number of BCD output digits (>= 1).
- SIGNED, 1, 1 = input is two's complement and is converted as magnitude plus sign code; 0 = unsigned.
- BLANK_LZ, 1, 1 = generate the leading-zero blank mask; 0 = blank_mask is held at all-zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a conversion of bin; sampled only in IDLE.
- bin  in  WIDTH  binary value, captured on the accepted start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the outputs update.
- bcd  out  DIGITS*4  result, digit 0 in [3:0].
- bcd_sgn  out  4  sign code: 4'b1010 = negative, 4'b1111 = positive / none.
- blank_mask  out  DIGITS  bit k = 1 means digit k is a leading zero and must be blanked.
- overflow  out  1  magnitude exceeded 10^DIGITS-1; bcd holds the low digits only.

Behaviour:
- Reset (rst high at a clock edge, any state):
  - State goes to IDLE; busy=0, done=0.
  - bcd=0, bcd_sgn=4'b1111, overflow=0.
  - blank_mask = all ones except bit 0 when BLANK_LZ=1; all-zero when BLANK_LZ=0.
  - An in-flight conversion is discarded and produces no done.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 moves to SHIFT and sets busy=1.
  - Magnitude capture: if SIGNED=1 and bin[WIDTH-1]=1, the shift register is loaded with -bin (WIDTH bits, unsigned interpretation) and the internal sign is set negative.
  - Otherwise the shift register is loaded with bin and the sign is positive.
  - Internal BCD accumulator cleared; bit counter cleared; internal overflow flag cleared.
- SHIFT, one iteration per cycle, WIDTH cycles:
  - Every 4-bit accumulator digit > 4 gets +3.
  - The adjusted accumulator is then shifted left by 1 with the shift-register MSB as the new LSB; the shift register shifts left.
  - If the bit shifted out of the accumulator's top is 1, the internal overflow flag is set (sticky).
  - After the WIDTH-th iteration, move to FINISH.
- FINISH, one cycle:
  - Register the accumulator into bcd, the sign into bcd_sgn, and the flag into overflow.
  - Compute blank_mask from the new bcd: bit k=1 iff digits DIGITS-1..k are all zero and k != 0. Digit 0 is never blanked, and overflow does not change masking.
  - done=1 for this cycle only; busy drops to 0. Next state IDLE.
- Latency: start accepted at edge N gives done high in the cycle after edge N+WIDTH+1. A new start may be accepted on the cycle after done.
- start while busy is ignored: no queueing, and bin changes during a conversion have no effect.
- Outputs hold their last values between done pulses.
- Most-negative input (0x8000 for WIDTH=16) converts to magnitude 2^(WIDTH-1), negative sign.
- bin=0 gives bcd=0, sign 4'b1111 and a mask with only digit 0 unblanked.
- SIGNED=0: bcd_sgn is always 4'b1111.

Test Plan:
- WIDTH=16, DIGITS=5: bin=16'd12345, start pulse → done exactly WIDTH+1 cycles after acceptance; bcd=20'h12345, bcd_sgn=4'b1010? no: 4'b1111, overflow=0, blank_mask=5'b00000.
- SIGNED=1: bin=16'hFFFF → bcd=20'h00001, bcd_sgn=4'b1010, blank_mask=5'b11110. bin=16'h8000 → bcd=20'h32768, sgn=4'b1010.
- DIGITS=4, SIGNED=0: bin=16'd12345 → overflow=1, bcd=16'h2345. Then bin=16'd9999 → overflow=0, bcd=16'h9999.
- bin=16'd42 → bcd=20'h00042, blank_mask=5'b11100. bin=0 → bcd=0, blank_mask=5'b11110. With BLANK_LZ=0 → mask always 0.
- Start while busy: second start with a different bin at cycle 5 → ignored; single done with the first result; busy stays high for the whole conversion.
- rst asserted at cycle 8 of a conversion → no done pulse; outputs return to reset values. A fresh start then converts correctly.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with start/busy/done handshake, optional sign handling, overflow and leading-zero mask.
module bin2bcd_seq #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DIGITS   = 5,
    parameter bit          SIGNED   = 1'b1,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic [3:0]            bcd_sgn,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  overflow
);

    localparam int unsigned BW = DIGITS * 4;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [3:0]  SGN_NEG = 4'b1010;
    localparam logic [3:0]  SGN_POS = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_sr;
    logic [BW-1:0]       r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_neg;
    logic                r_ovf;

    logic                w_neg;
    logic [WIDTH-1:0]    w_mag;
    logic [BW-1:0]       w_adj;
    logic [BW-1:0]       w_acc_next;
    logic                w_carry;
    logic [DIGITS-1:0]   w_mask;
    logic [DIGITS-1:0]   w_mask_rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == CW'(WIDTH - 1)) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Magnitude of the input; the most-negative value maps to 2^(WIDTH-1)
    always_comb begin
        w_neg = SIGNED && bin[WIDTH-1];
        w_mag = w_neg ? (~bin + WIDTH'(1)) : bin;
    end

    // Add-3 adjust of every digit above 4, then shift in the next magnitude bit
    always_comb begin
        w_adj = r_acc;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (r_acc[k*4 +: 4] > 4'd4) begin
                w_adj[k*4 +: 4] = r_acc[k*4 +: 4] + 4'd3;
            end
        end
        w_carry    = w_adj[BW-1];
        w_acc_next = {w_adj[BW-2:0], r_sr[WIDTH-1]};
    end

    // Leading-zero mask: digit k blanked when it and all higher digits are zero
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        w_mask     = '0;
        w_mask_rst = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            all_zero      = all_zero && (r_acc[k*4 +: 4] == 4'd0);
            w_mask[k]     = BLANK_LZ && all_zero && (k != 0);
            w_mask_rst[k] = BLANK_LZ && (k != 0);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            bcd_sgn    <= SGN_POS;
            blank_mask <= w_mask_rst;
            overflow   <= 1'b0;
            r_sr       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        r_sr  <= w_mag;
                        r_neg <= w_neg;
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                    r_ovf <= r_ovf | w_carry;
                end
                S_FINISH: begin
                    bcd        <= r_acc;
                    bcd_sgn    <= r_neg ? SGN_NEG : SGN_POS;
                    overflow   <= r_ovf;
                    blank_mask <= w_mask;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: three configurations driven in parallel,
// checked against an arithmetic reference model.
module tb_bin2bcd_seq;

    localparam int W = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bin;

    logic        a_busy, a_done, a_ovf;
    logic [19:0] a_bcd;
    logic [3:0]  a_sgn;
    logic [4:0]  a_mask;

    logic        b_busy, b_done, b_ovf;
    logic [15:0] b_bcd;
    logic [3:0]  b_sgn;
    logic [3:0]  b_mask;

    logic        c_busy, c_done, c_ovf;
    logic [19:0] c_bcd;
    logic [3:0]  c_sgn;
    logic [4:0]  c_mask;

    int n_cmp = 0;
    int n_bad = 0;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1), .BLANK_LZ(1'b1)) u_a (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(a_busy), .done(a_done), .bcd(a_bcd), .bcd_sgn(a_sgn),
        .blank_mask(a_mask), .overflow(a_ovf)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(4), .SIGNED(1'b0), .BLANK_LZ(1'b1)) u_b (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(b_busy), .done(b_done), .bcd(b_bcd), .bcd_sgn(b_sgn),
        .blank_mask(b_mask), .overflow(b_ovf)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1), .BLANK_LZ(1'b0)) u_c (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(c_busy), .done(c_done), .bcd(c_bcd), .bcd_sgn(c_sgn),
        .blank_mask(c_mask), .overflow(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Decimal reference: magnitude, low digits modulo 10^digits, mask from value range
    function automatic void model(input logic [15:0] b, input int digits, input bit sgnd,
                                  input bit blz, output logic [31:0] e_bcd,
                                  output logic [31:0] e_sgn, output logic [31:0] e_mask,
                                  output logic [31:0] e_ovf);
        int mag, lim, v, p;
        bit neg;
        neg = sgnd && b[15];
        mag = neg ? (65536 - int'(b)) : int'(b);
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e_ovf  = (mag >= lim) ? 32'd1 : 32'd0;
        e_sgn  = neg ? 32'hA : 32'hF;
        e_bcd  = '0;
        e_mask = '0;
        v = mag % lim;
        for (int k = 0; k < digits; k++) begin
            e_bcd[k*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        p = 1;
        for (int k = 0; k < digits; k++) begin
            if (k != 0 && blz && (mag % lim) < p) e_mask[k] = 1'b1;
            p = p * 10;
        end
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_a_busy"}, 32'(a_busy), 32'd0);
        chk({tag, "_a_done"}, 32'(a_done), 32'd0);
        chk({tag, "_a_bcd"},  32'(a_bcd),  32'd0);
        chk({tag, "_a_sgn"},  32'(a_sgn),  32'hF);
        chk({tag, "_a_mask"}, 32'(a_mask), 32'b11110);
        chk({tag, "_a_ovf"},  32'(a_ovf),  32'd0);
        chk({tag, "_b_bcd"},  32'(b_bcd),  32'd0);
        chk({tag, "_b_mask"}, 32'(b_mask), 32'b1110);
        chk({tag, "_b_busy"}, 32'(b_busy), 32'd0);
        chk({tag, "_c_mask"}, 32'(c_mask), 32'd0);
        chk({tag, "_c_sgn"},  32'(c_sgn),  32'hF);
    endtask

    // One conversion; optional stray start at glitch_at, optional reset pulse at rst_at
    task automatic run_conv(input logic [15:0] b, input int glitch_at, input int rst_at,
                            input string tag);
        logic [31:0] e_bcd, e_sgn, e_mask, e_ovf;
        int at_a, at_b, at_c, nd_a, nd_b, nd_c;
        bit busy_ok;
        at_a = -1; at_b = -1; at_c = -1;
        nd_a = 0;  nd_b = 0;  nd_c = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = 16'($urandom);
        for (int k = 0; k < 40; k++) begin
            if (a_done) begin nd_a++; if (at_a < 0) at_a = k; end
            if (b_done) begin nd_b++; if (at_b < 0) at_b = k; end
            if (c_done) begin nd_c++; if (at_c < 0) at_c = k; end
            if (rst_at < 0) begin
                if (k <= W && a_busy !== 1'b1) busy_ok = 1'b0;
                if (k == W + 1 && a_busy !== 1'b0) busy_ok = 1'b0;
            end
            start = (k == glitch_at);
            if (k == glitch_at) bin = b ^ 16'h5A5A;
            rst = (k == rst_at);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        if (rst_at >= 0) begin
            chk({tag, "_ndone_a"}, 32'(nd_a), 32'd0);
            chk({tag, "_ndone_b"}, 32'(nd_b), 32'd0);
            check_reset_values(tag);
        end else begin
            chk({tag, "_lat_a"},   32'(at_a), 32'(W + 1));
            chk({tag, "_lat_b"},   32'(at_b), 32'(W + 1));
            chk({tag, "_lat_c"},   32'(at_c), 32'(W + 1));
            chk({tag, "_ndone_a"}, 32'(nd_a), 32'd1);
            chk({tag, "_ndone_c"}, 32'(nd_c), 32'd1);
            chk({tag, "_busy_a"},  32'(busy_ok), 32'd1);
            model(b, 5, 1'b1, 1'b1, e_bcd, e_sgn, e_mask, e_ovf);
            chk({tag, "_a_bcd"},  32'(a_bcd),  e_bcd);
            chk({tag, "_a_sgn"},  32'(a_sgn),  e_sgn);
            chk({tag, "_a_mask"}, 32'(a_mask), e_mask);
            chk({tag, "_a_ovf"},  32'(a_ovf),  e_ovf);
            model(b, 4, 1'b0, 1'b1, e_bcd, e_sgn, e_mask, e_ovf);
            chk({tag, "_b_bcd"},  32'(b_bcd),  e_bcd);
            chk({tag, "_b_sgn"},  32'(b_sgn),  e_sgn);
            chk({tag, "_b_mask"}, 32'(b_mask), e_mask);
            chk({tag, "_b_ovf"},  32'(b_ovf),  e_ovf);
            model(b, 5, 1'b1, 1'b0, e_bcd, e_sgn, e_mask, e_ovf);
            chk({tag, "_c_bcd"},  32'(c_bcd),  e_bcd);
            chk({tag, "_c_sgn"},  32'(c_sgn),  e_sgn);
            chk({tag, "_c_mask"}, 32'(c_mask), e_mask);
            chk({tag, "_c_ovf"},  32'(c_ovf),  e_ovf);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Spot values with known answers, then model-driven cases
        run_conv(16'd12345, -1, -1, "d12345");
        chk("lit_a_12345", 32'(a_bcd), 32'h12345);
        chk("lit_b_12345_ovf", 32'(b_ovf), 32'd1);
        chk("lit_b_12345_bcd", 32'(b_bcd), 32'h2345);
        run_conv(16'hFFFF, -1, -1, "hFFFF");
        chk("lit_a_ffff_bcd", 32'(a_bcd), 32'h00001);
        chk("lit_a_ffff_sgn", 32'(a_sgn), 32'hA);
        chk("lit_a_ffff_mask", 32'(a_mask), 32'b11110);
        run_conv(16'h8000, -1, -1, "h8000");
        chk("lit_a_8000_bcd", 32'(a_bcd), 32'h32768);
        run_conv(16'd42, -1, -1, "d42");
        chk("lit_a_42_mask", 32'(a_mask), 32'b11100);
        run_conv(16'd0, -1, -1, "zero");
        run_conv(16'd9999, -1, -1, "d9999");
        chk("lit_b_9999_ovf", 32'(b_ovf), 32'd0);
        run_conv(16'd10000, -1, -1, "d10000");
        run_conv(16'h7FFF, -1, -1, "h7FFF");
        run_conv(16'd65535, -1, -1, "umax");

        run_conv(16'd31415, 5, -1, "glitch");
        run_conv(16'd27182, -1, 8, "midrst");
        run_conv(16'd777, -1, -1, "after_rst");

        for (int i = 0; i < 24; i++) begin
            run_conv(16'($urandom), -1, -1, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
